// File: rtl/rd_data_stage_mb_pkg.sv
// -----------------------------------------------------------------------------
// rd_data_stage_mb_pkg
// Shared encodings for the read-data stage:
//   - rd_src operand-source select codes
//   - rd_wrap high-byte address increment modes (6502 style)
//   - control-bundle field offsets, counted down from the MSB of the bundle
//   - FSM state encoding
// -----------------------------------------------------------------------------
package rd_data_stage_mb_pkg;

    typedef enum logic [1:0] {
        RDSRC_ZERO = 2'd0,
        RDSRC_DAT  = 2'd1,
        RDSRC_MEM  = 2'd2,
        RDSRC_FWD  = 2'd3
    } rd_src_e;

    // Code 3 is reserved and behaves as linear.
    typedef enum logic [1:0] {
        WRAP_LIN  = 2'd0,
        WRAP_PAGE = 2'd1,
        WRAP_ZP   = 2'd2,
        WRAP_RSVD = 2'd3
    } rd_wrap_e;

    typedef enum logic {
        IDLE     = 1'b0,
        FETCH_HI = 1'b1
    } state_e;

    // Control-bundle header layout, top bits down:
    //   [CTRL_IN_W-1 : CTRL_IN_W-2] rd_src
    //   [CTRL_IN_W-3]               rd_word
    //   [CTRL_IN_W-4 : CTRL_IN_W-5] rd_wrap
    // Each offset is the distance of the field's LSB below CTRL_IN_W.
    localparam int RDSRC_OFS  = 2;
    localparam int RDWORD_OFS = 3;
    localparam int RDWRAP_OFS = 5;
    localparam int CTRL_HDR_W = 5;

endpackage

// File: rtl/mux4.sv
// -----------------------------------------------------------------------------
// mux4
// Generic 4:1 multiplexer.
//   sel  in  2  select
//   d0..d3 in W data inputs
//   y    out W  selected input
// -----------------------------------------------------------------------------
module mux4 #(
    parameter int W = 16
) (
    input  logic [1:0]   sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic [W-1:0] d2,
    input  logic [W-1:0] d3,
    output logic [W-1:0] y
);

    always_comb begin
        case (sel)
            2'd0:    y = d0;
            2'd1:    y = d1;
            2'd2:    y = d2;
            default: y = d3;
        endcase
    end

endmodule

// File: rtl/rd_adr_inc.sv
// -----------------------------------------------------------------------------
// rd_adr_inc
// Combinational high-byte address generator for two-byte reads.
//   eff_adr  in  ADR_W  address of the low byte
//   rd_wrap  in  2      increment mode (linear / page-wrap / zero-page)
//   hi_adr   out ADR_W  address of the high byte
// Page-wrap reproduces the 6502 JMP (ind) quirk: the carry out of the low
// address byte is dropped, so 0x12FF pairs with 0x1200.
// -----------------------------------------------------------------------------
module rd_adr_inc
    import rd_data_stage_mb_pkg::*;
#(
    parameter int ADR_W = 16
) (
    input  logic [ADR_W-1:0] eff_adr,
    input  logic [1:0]       rd_wrap,
    output logic [ADR_W-1:0] hi_adr
);

    logic [7:0] lo_inc;

    assign lo_inc = eff_adr[7:0] + 8'd1;

    always_comb begin
        // NOTE: hi_adr gets a value on every path (default arm included), so no latch is inferred.
        case (rd_wrap_e'(rd_wrap))
            WRAP_PAGE: hi_adr = {eff_adr[ADR_W-1:8], lo_inc};
            WRAP_ZP:   hi_adr = ADR_W'(lo_inc);
            default:   hi_adr = eff_adr + ADR_W'(1);
        endcase
    end

endmodule

// File: rtl/rd_data_stage_mb.sv
// -----------------------------------------------------------------------------
// rd_data_stage_mb
// Read-data pipeline stage. Selects the operand (zero, pass-through, memory,
// forwarded) and can assemble a little-endian word from two byte reads over
// the 8-bit memory port, holding upstream via busy_o while the high byte is
// fetched.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-low reset
//   gbl_stl_i, mem_stl_i     stalls: every register holds
//   wait_to_fill_pipe_i      bubble: outputs hold, vld_o drops
//   dat_i, forwd_i           pass-through / forwarded operands
//   eff_adr_i                effective (low-byte) address
//   control_signal_i         {rd_src, rd_word, rd_wrap, ..., passthrough bits}
//   mem_rd_dat_i             memory data, valid the same cycle as the address
//   control_signal_o, dat_o, eff_adr_o, vld_o   registered results
//   mem_rd_adr_o, mem_rd_en_o                   combinational memory request
//   busy_o                   high in FETCH_HI; upstream holds its inputs
//
// Optional: define RDDATA_DEBUG_EN to add debug_o = {state, busy_o, mem_rd_adr_o}.
// -----------------------------------------------------------------------------
module rd_data_stage_mb
    import rd_data_stage_mb_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int ADR_W      = 16,
    parameter int MEM_W      = 8,
    parameter int CTRL_IN_W  = 24,
    parameter int CTRL_OUT_W = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  gbl_stl_i,
    input  logic                  wait_to_fill_pipe_i,
    input  logic [DATA_W-1:0]     dat_i,
    input  logic [DATA_W-1:0]     forwd_i,
    input  logic [ADR_W-1:0]      eff_adr_i,
    input  logic [CTRL_IN_W-1:0]  control_signal_i,
    input  logic                  mem_stl_i,
    input  logic [MEM_W-1:0]      mem_rd_dat_i,
    output logic [CTRL_OUT_W-1:0] control_signal_o,
    output logic [DATA_W-1:0]     dat_o,
    output logic [ADR_W-1:0]      eff_adr_o,
    output logic [ADR_W-1:0]      mem_rd_adr_o,
    output logic                  mem_rd_en_o,
    output logic                  busy_o,
    output logic                  vld_o
`ifdef RDDATA_DEBUG_EN
    ,
    output logic [ADR_W+1:0]      debug_o
`endif
);

    // ---------------------------------------------------------------- decode
    rd_src_e    rd_src;
    logic       rd_word;
    logic [1:0] rd_wrap;

    assign rd_src  = rd_src_e'(control_signal_i[CTRL_IN_W-RDSRC_OFS +: 2]);
    assign rd_word = control_signal_i[CTRL_IN_W-RDWORD_OFS];
    assign rd_wrap = control_signal_i[CTRL_IN_W-RDWRAP_OFS +: 2];

    // Bundle bits between the header and the forwarded field are not used here.
    generate
        if (CTRL_OUT_W < CTRL_IN_W - CTRL_HDR_W) begin : g_spare
            logic unused_ctrl;
            assign unused_ctrl = ^control_signal_i[CTRL_IN_W-CTRL_HDR_W-1:CTRL_OUT_W];
        end
    endgenerate

    logic stall;
    logic adv;

    assign stall = gbl_stl_i | mem_stl_i;
    assign adv   = ~stall & ~wait_to_fill_pipe_i;

    // ------------------------------------------------------------ state/regs
    state_e            state_q;
    state_e            state_d;
    logic [MEM_W-1:0]  lo_q;
    logic              lo_en;
    logic              cap_en;
    logic [DATA_W-1:0] dat_d;

    // ------------------------------------------------------------- datapath
    logic [ADR_W-1:0]  hi_adr;
    logic [DATA_W-1:0] mux_y;
    logic [DATA_W-1:0] mem_byte;
    logic [DATA_W-1:0] mem_word;

    rd_adr_inc #(.ADR_W(ADR_W)) u_adr_inc (
        .eff_adr (eff_adr_i),
        .rd_wrap (rd_wrap),
        .hi_adr  (hi_adr)
    );

    // Memory data is zero-extended; the word is little-endian {hi, lo}.
    assign mem_byte = DATA_W'(mem_rd_dat_i);
    assign mem_word = DATA_W'({mem_rd_dat_i, lo_q});

    mux4 #(.W(DATA_W)) u_src_mux (
        .sel (rd_src),
        .d0  ('0),
        .d1  (dat_i),
        .d2  (mem_byte),
        .d3  (forwd_i),
        .y   (mux_y)
    );

    // ---------------------------------------------------- memory request
    assign busy_o       = (state_q == FETCH_HI);
    assign mem_rd_adr_o = busy_o ? hi_adr : eff_adr_i;
    // In IDLE the read is suppressed during a fill bubble since nothing consumes it.
    assign mem_rd_en_o  = busy_o | ((rd_src == RDSRC_MEM) & ~wait_to_fill_pipe_i);

    // ------------------------------------------------------ next-state/ctrl
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latch).
        state_d = state_q;
        lo_en   = 1'b0;
        cap_en  = 1'b0;
        dat_d   = mux_y;
        case (state_q)
            IDLE: begin
                if (adv) begin
                    if ((rd_src == RDSRC_MEM) && rd_word) begin
                        lo_en   = 1'b1;
                        state_d = FETCH_HI;
                    end else begin
                        cap_en = 1'b1;
                    end
                end
            end
            FETCH_HI: begin
                dat_d = mem_word;
                if (adv) begin
                    cap_en  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments, so every register samples pre-edge values regardless of block order.
        if (!rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // -------------------------------------------------------- output regs
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            lo_q             <= '0;
            dat_o            <= '0;
            eff_adr_o        <= '0;
            control_signal_o <= '0;
            vld_o            <= 1'b0;
        end else begin
            if (lo_en) begin
                lo_q <= mem_rd_dat_i;
            end
            if (cap_en) begin
                dat_o            <= dat_d;
                eff_adr_o        <= eff_adr_i;
                control_signal_o <= control_signal_i[CTRL_OUT_W-1:0];
                vld_o            <= 1'b1;
            end else if (!stall) begin
                // Advancing into FETCH_HI or sitting in a fill bubble: no new result.
                vld_o <= 1'b0;
            end
        end
    end

`ifdef RDDATA_DEBUG_EN
    assign debug_o = {state_q, busy_o, mem_rd_adr_o};
`else
    // Debug tap not built.
`endif

endmodule

// File: tb/tb_rd_data_stage_mb.sv
// -----------------------------------------------------------------------------
// tb_rd_data_stage_mb
// Directed bench for rd_data_stage_mb with a 64 KiB byte memory model that
// answers combinationally on mem_rd_adr_o.
// -----------------------------------------------------------------------------
module tb_rd_data_stage_mb;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        gbl_stl_i;
    logic        wait_to_fill_pipe_i;
    logic [15:0] dat_i;
    logic [15:0] forwd_i;
    logic [15:0] eff_adr_i;
    logic [23:0] control_signal_i;
    logic        mem_stl_i;
    logic [7:0]  mem_rd_dat_i;
    logic [15:0] control_signal_o;
    logic [15:0] dat_o;
    logic [15:0] eff_adr_o;
    logic [15:0] mem_rd_adr_o;
    logic        mem_rd_en_o;
    logic        busy_o;
    logic        vld_o;

    logic [7:0] mem [0:65535];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk_i = ~clk_i;

    assign mem_rd_dat_i = mem[mem_rd_adr_o];

    rd_data_stage_mb dut (
        .clk_i               (clk_i),
        .rst_i               (rst_i),
        .gbl_stl_i           (gbl_stl_i),
        .wait_to_fill_pipe_i (wait_to_fill_pipe_i),
        .dat_i               (dat_i),
        .forwd_i             (forwd_i),
        .eff_adr_i           (eff_adr_i),
        .control_signal_i    (control_signal_i),
        .mem_stl_i           (mem_stl_i),
        .mem_rd_dat_i        (mem_rd_dat_i),
        .control_signal_o    (control_signal_o),
        .dat_o               (dat_o),
        .eff_adr_o           (eff_adr_o),
        .mem_rd_adr_o        (mem_rd_adr_o),
        .mem_rd_en_o         (mem_rd_en_o),
        .busy_o              (busy_o),
        .vld_o               (vld_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One clock edge; sample 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Header {rd_src, rd_word, rd_wrap}, three spare bits set to 1 so they must be dropped.
    function automatic logic [23:0] ctrl(input logic [1:0] src, input logic word,
                                         input logic [1:0] wrap, input logic [15:0] lo);
        return {src, word, wrap, 3'b111, lo};
    endfunction

    // Two-cycle word read starting from IDLE; checks the hi address then the word.
    task automatic word_read(input string tag, input logic [15:0] adr, input logic [1:0] wrap,
                             input logic [15:0] exp_hi_adr, input logic [15:0] exp_word);
        eff_adr_i        = adr;
        control_signal_i = ctrl(2'd2, 1'b1, wrap, 16'h0F0F);
        tick();
        check({tag, " busy"}, busy_o, 1);
        check({tag, " hi_adr"}, mem_rd_adr_o, exp_hi_adr);
        tick();
        check({tag, " word"}, dat_o, exp_word);
        check({tag, " vld"}, vld_o, 1);
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEE;

        rst_i               = 1'b0;
        gbl_stl_i           = 1'b0;
        wait_to_fill_pipe_i = 1'b0;
        mem_stl_i           = 1'b0;
        dat_i               = 16'h0;
        forwd_i             = 16'h0;
        eff_adr_i           = 16'h0;
        control_signal_i    = ctrl(2'd2, 1'b0, 2'd0, 16'hFFFF);
        tick();
        tick();
        check("rst dat_o", dat_o, 0);
        check("rst vld_o", vld_o, 0);
        check("rst eff_adr_o", eff_adr_o, 0);
        check("rst ctrl_o", control_signal_o, 0);
        check("rst busy_o", busy_o, 0);
        rst_i = 1'b1;

        // Byte memory read.
        mem[16'h1234]    = 8'hAB;
        eff_adr_i        = 16'h1234;
        control_signal_i = ctrl(2'd2, 1'b0, 2'd0, 16'hC0DE);
        #1;
        check("byte rd_en", mem_rd_en_o, 1);
        check("byte rd_adr", mem_rd_adr_o, 16'h1234);
        check("byte busy pre", busy_o, 0);
        tick();
        check("byte dat_o", dat_o, 16'h00AB);
        check("byte eff_adr_o", eff_adr_o, 16'h1234);
        check("byte vld_o", vld_o, 1);
        check("byte ctrl_o", control_signal_o, 16'hC0DE);
        check("byte busy post", busy_o, 0);

        // Word read with page wrap (JMP indirect quirk).
        mem[16'h12FF]    = 8'h34;
        mem[16'h1200]    = 8'h56;
        eff_adr_i        = 16'h12FF;
        control_signal_i = ctrl(2'd2, 1'b1, 2'd1, 16'h1111);
        tick();
        check("page busy", busy_o, 1);
        check("page hi_adr", mem_rd_adr_o, 16'h1200);
        check("page rd_en", mem_rd_en_o, 1);
        check("page vld low", vld_o, 0);
        check("page dat hold", dat_o, 16'h00AB);
        tick();
        check("page word", dat_o, 16'h5634);
        check("page vld", vld_o, 1);
        check("page eff_adr_o", eff_adr_o, 16'h12FF);
        check("page ctrl_o", control_signal_o, 16'h1111);
        check("page busy done", busy_o, 0);

        // Zero-page, linear and reserved increments.
        mem[16'h00FF] = 8'h11;
        mem[16'h0000] = 8'h22;
        mem[16'hFFFF] = 8'h33;
        mem[16'h0100] = 8'h44;
        mem[16'h1300] = 8'h77;
        word_read("zp", 16'h00FF, 2'd2, 16'h0000, 16'h2211);
        word_read("lin ffff", 16'hFFFF, 2'd0, 16'h0000, 16'h2233);
        word_read("lin 00ff", 16'h00FF, 2'd0, 16'h0100, 16'h4411);
        word_read("rsvd", 16'h12FF, 2'd3, 16'h1300, 16'h7734);

        // Global stall in IDLE: everything holds, including vld_o.
        gbl_stl_i        = 1'b1;
        eff_adr_i        = 16'h1234;
        control_signal_i = ctrl(2'd2, 1'b0, 2'd0, 16'h2222);
        tick();
        check("gstl dat hold", dat_o, 16'h7734);
        check("gstl vld hold", vld_o, 1);
        check("gstl adr hold", eff_adr_o, 16'h12FF);
        gbl_stl_i = 1'b0;

        // Memory stall during FETCH_HI.
        mem[16'h2000]    = 8'h9A;
        mem[16'h2001]    = 8'hBC;
        eff_adr_i        = 16'h2000;
        control_signal_i = ctrl(2'd2, 1'b1, 2'd0, 16'h3333);
        tick();
        check("mstl enter busy", busy_o, 1);
        mem_stl_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("mstl busy", busy_o, 1);
            check("mstl vld", vld_o, 0);
            check("mstl dat hold", dat_o, 16'h7734);
            check("mstl hi_adr", mem_rd_adr_o, 16'h2001);
        end
        mem_stl_i = 1'b0;
        tick();
        check("mstl word", dat_o, 16'hBC9A);
        check("mstl vld", vld_o, 1);
        check("mstl busy done", busy_o, 0);

        // Forwarded source, then a fill bubble.
        forwd_i          = 16'hBEEF;
        control_signal_i = ctrl(2'd3, 1'b0, 2'd0, 16'h4444);
        tick();
        check("fwd dat", dat_o, 16'hBEEF);
        check("fwd vld", vld_o, 1);
        wait_to_fill_pipe_i = 1'b1;
        control_signal_i    = ctrl(2'd2, 1'b0, 2'd0, 16'h5555);
        #1;
        check("bubble rd_en", mem_rd_en_o, 0);
        tick();
        check("bubble vld", vld_o, 0);
        check("bubble dat hold", dat_o, 16'hBEEF);
        check("bubble ctrl hold", control_signal_o, 16'h4444);
        wait_to_fill_pipe_i = 1'b0;

        // Zero and pass-through sources.
        dat_i            = 16'h1357;
        control_signal_i = ctrl(2'd1, 1'b0, 2'd0, 16'h6666);
        tick();
        check("dat src", dat_o, 16'h1357);
        control_signal_i = ctrl(2'd0, 1'b0, 2'd0, 16'h7777);
        tick();
        check("zero src", dat_o, 16'h0000);
        check("zero vld", vld_o, 1);

        // Reset during FETCH_HI aborts the fetch.
        eff_adr_i        = 16'h2000;
        control_signal_i = ctrl(2'd2, 1'b1, 2'd0, 16'h8888);
        tick();
        check("rstfh busy pre", busy_o, 1);
        rst_i = 1'b0;
        tick();
        check("rstfh busy", busy_o, 0);
        check("rstfh dat", dat_o, 0);
        check("rstfh vld", vld_o, 0);
        check("rstfh eff_adr_o", eff_adr_o, 0);
        check("rstfh ctrl_o", control_signal_o, 0);
        check("rstfh rd_adr idle", mem_rd_adr_o, 16'h2000);
        rst_i = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
